// File: rtl/rr_req_arbiter8_pkg.sv
// Shared constants, FSM encoding and the one-hot-to-index helper for the 8-way round-robin arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rr_req_arbiter8_pkg;

    localparam int N_REQ = 8;
    localparam int PTR_W = 3;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Index of the hot bit; the OR-reduction form maps straight onto an 8-to-3 encoder.
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | PTR_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_req_arbiter8_pick8.sv
// Circular first-one finder: lowest set req bit at or after ptr, wrapping mod 8.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs every cycle.
module rr_pick8
    import rr_req_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] sel_onehot,
    output logic [PTR_W-1:0] sel_idx,
    output logic             any
);

    // Scan from the far end back towards ptr so the nearest set bit wins.
    always_comb begin
        sel_idx = ptr;
        any     = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[ptr + PTR_W'(i)]) begin
                sel_idx = ptr + PTR_W'(i);
                any     = 1'b1;
            end
        end
        sel_onehot = any ? (N_REQ'(1) << sel_idx) : '0;
    end

endmodule

// File: rtl/rr_req_arbiter8.sv
// Round-robin arbiter for 8 requesters with a registered, strictly one-hot grant and a hold timeout.
// Latency: req sampled at one edge gives gnt on the next edge; one all-zero cycle between grants.
// Backpressure: holder frees the grant via rel, by dropping its req, or by timeout (tmo pulse).
module rr_req_arbiter8
    import rr_req_arbiter8_pkg::*;
#(
    parameter  int N        = 8,
    parameter  int MAX_HOLD = 16,
    localparam int CW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         rel,
    output logic [N-1:0] gnt,
    output logic         gnt_vld,
    output logic         tmo
);

    localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;

    logic [0:0]       state;
    logic [PTR_W-1:0] ptr;
    logic [CW-1:0]    hold_cnt;

    logic [N_REQ-1:0] pick_oh;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_any;

    logic [PTR_W-1:0] gnt_idx;
    logic             holder_req;
    logic             hold_expired;
    logic             grant_exit;
    logic             unused_pick;

    rr_pick8 u_pick (
        .req        (req),
        .ptr        (ptr),
        .sel_onehot (pick_oh),
        .sel_idx    (pick_idx),
        .any        (pick_any)
    );

    // The finder's index output serves other arbiters; here the one-hot form is registered directly.
    assign unused_pick = ^pick_idx;

    assign gnt_vld = |gnt;

    // Exit decode for the current holder; timeout only counts when enabled.
    always_comb begin
        gnt_idx      = onehot_to_idx(gnt);
        holder_req   = |(req & gnt);
        hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
        grant_exit   = rel || !holder_req || hold_expired;
    end

    // Grant FSM: pick in IDLE, hold in GRANT, clear for one dead cycle on any exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            tmo      <= 1'b0;
        end else begin
            tmo <= 1'b0;
            if (state == ST_IDLE) begin
                if (pick_any) begin
                    gnt      <= pick_oh;
                    hold_cnt <= '0;
                    state    <= ST_GRANT;
                end
            end else begin
                if (grant_exit) begin
                    gnt   <= '0;
                    ptr   <= gnt_idx + PTR_W'(1);
                    state <= ST_IDLE;
                    // Flag a timeout only when nothing else would have ended the grant.
                    tmo   <= hold_expired && !rel && holder_req;
                end else if (hold_cnt != '1) begin
                    hold_cnt <= hold_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_req_arbiter8.sv
module tb_rr_req_arbiter8;
    import rr_req_arbiter8_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       rel;
    logic [7:0] gnt;
    logic       gnt_vld;
    logic       tmo;

    int checks = 0;
    int errors = 0;

    rr_req_arbiter8 #(.N(8), .MAX_HOLD(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .tmo     (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-hot invariant on every falling edge outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert ($onehot0(gnt)) else begin
                errors++;
                $display("FAIL onehot gnt=%h required popcount<=1", gnt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        rel   = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        rel   = 1'b0;
        #1;
        checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt got=%h exp=00", gnt); end
        checks++; if (gnt_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", gnt_vld); end
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL reset_tmo got=%b exp=0", tmo); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL idle_gnt got=%h exp=00", gnt); end
    endtask

    task automatic test_priority_rotation();
        logic [7:0] exp;
        do_reset();
        req = 8'hFF;
        step();
        checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL prio_first got=%h exp=01", gnt); end
        checks++; if (gnt_vld !== 1'b1) begin errors++; $display("FAIL prio_vld got=%b exp=1", gnt_vld); end
        for (int i = 1; i <= 8; i++) begin
            rel = 1'b1;
            step();
            rel = 1'b0;
            checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL rot_dead%0d got=%h exp=00", i, gnt); end
            checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rot_tmo%0d got=%b exp=0", i, tmo); end
            step();
            exp = 8'h01 << (i % 8);
            checks++; if (gnt !== exp) begin errors++; $display("FAIL rot_gnt%0d got=%h exp=%h", i, gnt, exp); end
        end
        // rel in IDLE is ignored and not stored.
        req = 8'h00;
        step();
        rel = 1'b1;
        step();
        rel = 1'b0;
        req = 8'h02;
        step();
        checks++; if (gnt !== 8'h02) begin errors++; $display("FAIL rel_idle got=%h exp=02", gnt); end
        step();
        checks++; if (gnt !== 8'h02) begin errors++; $display("FAIL rel_not_stored got=%h exp=02", gnt); end
        req = 8'h00;
        step();
    endtask

    task automatic test_sparse();
        do_reset();
        req = 8'h10;
        step();
        checks++; if (gnt !== 8'h10) begin errors++; $display("FAIL sparse_i4 got=%h exp=10", gnt); end
        rel = 1'b1;
        step();
        rel = 1'b0;
        req = 8'h21;
        step();
        checks++; if (gnt !== 8'h20) begin errors++; $display("FAIL sparse_i5 got=%h exp=20", gnt); end
        // Other requesters changing during a grant do not disturb it.
        req = 8'hE1;
        step();
        checks++; if (gnt !== 8'h20) begin errors++; $display("FAIL sparse_stable got=%h exp=20", gnt); end
        req = 8'h21;
        rel = 1'b1;
        step();
        rel = 1'b0;
        step();
        checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL sparse_wrap got=%h exp=01", gnt); end
        req = 8'h00;
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        req = 8'h10;
        step();
        checks++; if (gnt !== 8'h10) begin errors++; $display("FAIL tmo_start got=%h exp=10", gnt); end
        for (int c = 1; c <= 15; c++) begin
            step();
            checks++; if (gnt !== 8'h10 || tmo !== 1'b0) begin
                errors++; $display("FAIL tmo_hold%0d got=%h/%b exp=10/0", c, gnt, tmo);
            end
        end
        step();
        checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL tmo_clear got=%h exp=00", gnt); end
        checks++; if (tmo !== 1'b1) begin errors++; $display("FAIL tmo_pulse got=%b exp=1", tmo); end
        step();
        checks++; if (gnt !== 8'h10) begin errors++; $display("FAIL tmo_regrant got=%h exp=10", gnt); end
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL tmo_one_cycle got=%b exp=0", tmo); end
    endtask

    // Continues from the re-grant of i4 left by test_timeout (hold count restarted at 0).
    task automatic test_simultaneous();
        for (int c = 1; c <= 15; c++) begin
            step();
        end
        checks++; if (gnt !== 8'h10) begin errors++; $display("FAIL sim_before got=%h exp=10", gnt); end
        rel = 1'b1;
        step();
        rel = 1'b0;
        checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL sim_clear got=%h exp=00", gnt); end
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL sim_tmo got=%b exp=0", tmo); end
        step();
        checks++; if (gnt !== 8'h10) begin errors++; $display("FAIL drop_grant got=%h exp=10", gnt); end
        step();
        step();
        req = 8'h00;
        step();
        checks++; if (gnt !== 8'h00 || tmo !== 1'b0) begin
            errors++; $display("FAIL drop_clear got=%h/%b exp=00/0", gnt, tmo);
        end
        // ptr must now be 5: with i0 and i4 requesting, i0 wins.
        req = 8'h11;
        step();
        checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL drop_ptr got=%h exp=01", gnt); end
        req = 8'h00;
        step();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 8'h08;
        step();
        checks++; if (gnt !== 8'h08) begin errors++; $display("FAIL mid_grant got=%h exp=08", gnt); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL mid_rst_gnt got=%h exp=00", gnt); end
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL mid_rst_tmo got=%b exp=0", tmo); end
        #1;
        rst_n = 1'b1;
        step();
        checks++; if (gnt !== 8'h08) begin errors++; $display("FAIL mid_regrant got=%h exp=08", gnt); end
        req = 8'h00;
        step();
    endtask

    task automatic test_encoder();
        logic [7:0]       exp_oh;
        logic [PTR_W-1:0] enc;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_oh = 8'h01 << i;
            req = exp_oh;
            step();
            enc = onehot_to_idx(gnt);
            checks++; if (gnt !== exp_oh || gnt_vld !== 1'b1) begin
                errors++; $display("FAIL enc_gnt%0d got=%h/%b exp=%h/1", i, gnt, gnt_vld, exp_oh);
            end
            checks++; if (enc !== 3'(i)) begin errors++; $display("FAIL enc_idx%0d got=%0d exp=%0d", i, enc, i); end
            req = 8'h00;
            step();
            checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL enc_dead%0d got=%h exp=00", i, gnt); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        rel   = 1'b0;
        test_reset();
        test_priority_rotation();
        test_sparse();
        test_timeout();
        test_simultaneous();
        test_reset_mid_grant();
        test_encoder();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_req_arbiter8.md
Name: rr_req_arbiter8

Overview:
- Round-robin arbiter for 8 request lines.
- Produces a registered, strictly one-hot grant vector that feeds the 8-to-3 encoder stage directly.
- The encoder's inputs must never see more than one hot bit; this block guarantees that and bounds how long any requester may hold the grant.

Parameters:
- N, 8, number of request lines; fixed at 8 to match the encoder width.
- MAX_HOLD, 16, maximum cycles a grant may be held before forced revocation; 0 disables the timeout.
- CW, $clog2(MAX_HOLD+1), hold-counter width; derived, not overridden.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request lines; bit k = requester k; level-sensitive.
- rel  input  1  release strobe from the current grant holder; one-cycle pulse.
- gnt  output  8  registered one-hot grant; all-zero when idle; drives encoder i0..i7.
- gnt_vld  output  1  high while gnt is non-zero.
- tmo  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset: gnt=8'h00, gnt_vld=0, tmo=0, ptr=0, hold_cnt=0, state=IDLE. Reset applies immediately on rst_n low, including mid-grant. The first grant after reset uses ptr=0, so i0 has top priority.
- States are IDLE and GRANT.
- IDLE:
  - If req != 0, select the first set bit k scanning ptr, ptr+1, ..., ptr+7 (mod 8).
  - Next edge: gnt=1<<k, gnt_vld=1, hold_cnt=0, state=GRANT.
  - Latency: req sampled at edge n gives gnt valid after edge n+1 (1 cycle).
- GRANT:
  - gnt is stable. hold_cnt increments by 1 per cycle and saturates at 2^CW-1.
  - Exit conditions, evaluated each cycle:
    - (a) rel=1
    - (b) req[k]=0, i.e. the holder dropped its request
    - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1
  - On exit:
    - gnt=0, gnt_vld=0, ptr=(k+1) mod 8, state=IDLE.
    - Exactly one dead cycle follows, so the encoder sees all-zero between grants.
  - tmo=1 for one cycle, coincident with the gnt-clear edge, only when (c) is the sole cause.
  - Simultaneous events: if (a) or (b) holds together with (c), no tmo pulse.
- rel in IDLE is ignored. A rel pulse is not stored.
- Changes on req bits other than k during GRANT are ignored until the arbiter returns to IDLE.
- One-hot invariant: gnt has popcount 0 or 1 in every cycle. Any violation is a design bug; an assertion is mandatory in the bench.
- Pointer wrap: k=7 sets ptr=0.
- Fairness: with all 8 lines continuously asserted, grants rotate 0,1,...,7,0,...
- Every requester is granted within 8 grant periods, each period at most MAX_HOLD+1 cycles.
- Arithmetic: ptr is 3-bit and wraps naturally. The rotate-and-scan is purely combinational on registered ptr; only gnt, ptr, hold_cnt, state and tmo are registered.

Decomposition:
- Shared package holds: N_REQ=8, PTR_W=3, state encoding (IDLE=1'b0, GRANT=1'b1), and the one-hot-to-index function shared with the encoder bench checker.
- One natural sub-module, rr_pick8: combinational circular first-one finder.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: sel_onehot[7:0], sel_idx[2:0], any.
  - Reusable by later arbiters.

Test Plan:
- Reset mid-grant: grant i3, pull rst_n low between edges -> gnt=00 immediately, tmo=0. After release, req=8'h08 -> gnt=8'h08 one cycle later.
- Priority after reset: req=8'hFF -> gnt=8'h01. Pulse rel -> dead cycle gnt=00, then gnt=8'h02. Continue releasing -> 04,08,...,80, then 01 (wrap).
- Sparse rotation: ptr=5 (after releasing i4), req=8'h21 -> gnt=8'h20. Release -> gnt=8'h01.
- Timeout: MAX_HOLD=16, req=8'h10 held, no rel -> gnt=8'h10 for exactly 16 cycles, then gnt=00 with tmo=1 for one cycle. Re-grant to i4 on the following cycle while req persists.
- Simultaneous: rel asserted on the cycle hold_cnt==15 -> gnt clears, tmo stays 0. Also drop req[k] mid-grant -> gnt clears next edge, ptr advances.
- End-to-end with encoder: gnt drives the encoder inputs for all 8 single requests -> encoder output equals index 0..7 in order. The one-hot assertion holds for the whole run.
